pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32I core.
- Takes the load-use stall request and branch-taken flush request from hazard detection, the data-memory ready handshake, and debug halt/step controls.
- Produces per-stage register enables, flush/bubble strobes and the PC redirect strobe.
- Keeps saturating performance counters; sits between the hazard/forwarding logic and the pipeline registers.

---
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between hazard detection, the pipeline sequencer and the stage registers.
// master = hazard/debug side driving requests; slave = the sequencer.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             lu_stall_req;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             dbg_halt;
  logic             dbg_step;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_bubble;
  logic             mem_wb_bubble;
  logic             pc_redirect;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output lu_stall_req, branch_taken, mem_req, mem_ready, dbg_halt, dbg_step,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble, pc_redirect,
    input  halted, mem_err, cyc_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  lu_stall_req, branch_taken, mem_req, mem_ready, dbg_halt, dbg_step,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble, pc_redirect,
    output halted, mem_err, cyc_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stage enables, flush/bubble strobes,
// debug halt/step, data-memory wait with timeout, and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2,
    STEP     = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] tmo_reg, tmo_next;
  logic        mem_err_reg, mem_err_next;

  logic mem_stall;
  logic freeze;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble, pc_redirect;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= RUN;
      tmo_reg     <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tmo_reg     <= tmo_next;
      mem_err_reg <= mem_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tmo_next      = tmo_reg;
    mem_err_next  = mem_err_reg;
    freeze        = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    pc_redirect   = 1'b0;

    case (state_reg)
      RUN, STEP: begin
        if (mem_stall) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
        end else begin
          state_next = bus.dbg_halt ? HALTED : RUN;
        end
      end
      MEM_WAIT: begin
        // A pending halt waits here until the access completes or times out.
        if (bus.mem_ready) begin
          state_next = bus.dbg_halt ? HALTED : RUN;
          tmo_next   = '0;
        end else begin
          freeze = 1'b1;
          if (tmo_reg == TMO_LAST) begin
            mem_err_next = 1'b1;
            state_next   = RUN;
            tmo_next     = '0;
          end else begin
            tmo_next = tmo_reg + 16'd1;
          end
        end
      end
      HALTED: begin
        freeze = 1'b1;
        if (bus.dbg_step) begin
          state_next = STEP;
        end else if (!bus.dbg_halt) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    // Frozen: only MEM/WB moves, carrying a NOP so WB does not repeat an instruction.
    if (freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (bus.lu_stall_req) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // Counter order: 0 = cycles, 1 = stalled cycles, 2 = redirects.
  logic [2:0]            cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_q;

  assign cnt_inc = {pc_redirect, ~pc_en, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.mem_wb_en     = mem_wb_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_bubble = ex_mem_bubble;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.pc_redirect   = pc_redirect;
  assign bus.halted        = (state_reg == HALTED);
  assign bus.mem_err       = mem_err_reg;
  assign bus.cyc_cnt       = cnt_q[0];
  assign bus.stall_cnt     = cnt_q[1];
  assign bus.flush_cnt     = cnt_q[2];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: stimulus pushes expected outputs into a
// queue, a monitor pops and compares mid-cycle.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  // Outputs: {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_flush,id_ex_flush,ex_mem_bubble,mem_wb_bubble,pc_redirect}
  localparam logic [9:0] ADV = 10'b11111_00000;
  localparam logic [9:0] MST = 10'b00001_00010;
  localparam logic [9:0] LUS = 10'b00011_00100;
  localparam logic [9:0] BRT = 10'b11111_11001;

  // Inputs: {lu_stall_req,branch_taken,mem_req,mem_ready,dbg_halt,dbg_step}
  localparam logic [5:0] IDLE   = 6'b000000;
  localparam logic [5:0] MSTALL = 6'b001000;
  localparam logic [5:0] MDONEB = 6'b011100;
  localparam logic [5:0] LU_BR  = 6'b110000;
  localparam logic [5:0] BR     = 6'b010000;
  localparam logic [5:0] LU     = 6'b100000;
  localparam logic [5:0] HALT   = 6'b000010;
  localparam logic [5:0] HSTEP  = 6'b000011;
  localparam logic [5:0] MSTH   = 6'b001010;
  localparam logic [5:0] MDONEH = 6'b001110;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [11:0]     ctrl;
    logic [3*CW-1:0] cnt;
    int              id;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_bad = 0;
  int vec_id = 0;
  logic [CW-1:0] e_cyc = '0, e_stall = '0, e_flush = '0;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic drive(input logic [5:0] in);
    {bus.lu_stall_req, bus.branch_taken, bus.mem_req,
     bus.mem_ready, bus.dbg_halt, bus.dbg_step} = in;
  endtask

  task automatic push(input logic [9:0] o, input logic h, input logic err);
    exp_t e;
    e.ctrl = {o, h, err};
    e.cnt  = {e_cyc, e_stall, e_flush};
    e.id   = vec_id;
    q.push_back(e);
    vec_id++;
  endtask

  // One clock of stimulus; expected counters advance only after the edge.
  task automatic cyc(input logic [5:0] in, input logic [9:0] o, input logic h, input logic err);
    drive(in);
    push(o, h, err);
    @(posedge clk);
    #1;
    e_cyc = sat(e_cyc);
    if (!o[9]) e_stall = sat(e_stall);
    if (o[0])  e_flush = sat(e_flush);
  endtask

  // Reset drops between edges, so the monitor sees the cleared state before any clock.
  task automatic do_reset();
    rstn = 1'b0;
    drive(IDLE);
    e_cyc = '0; e_stall = '0; e_flush = '0;
    push(ADV, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [11:0]     act_ctrl;
    logic [3*CW-1:0] act_cnt;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act_ctrl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                    bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_bubble, bus.mem_wb_bubble,
                    bus.pc_redirect, bus.halted, bus.mem_err};
        act_cnt = {bus.cyc_cnt, bus.stall_cnt, bus.flush_cnt};
        n_chk++;
        if (act_ctrl !== e.ctrl) begin
          n_bad++;
          $display("FAIL ctrl vec=%0d got=%b exp=%b", e.id, act_ctrl, e.ctrl);
        end
        n_chk++;
        if (act_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL counters vec=%0d got=%h exp=%h", e.id, act_cnt, e.cnt);
        end
        $display("vec=%0d ctrl=%b cnt=%h", e.id, act_ctrl, act_cnt);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    drive(IDLE);
    @(posedge clk);
    #1;

    // Idle run after reset.
    do_reset();
    repeat (10) cyc(IDLE, ADV, 1'b0, 1'b0);
    cyc(IDLE, ADV, 1'b0, 1'b0);

    // Memory wait, then completion with a taken branch.
    do_reset();
    repeat (3) cyc(MSTALL, MST, 1'b0, 1'b0);
    cyc(MDONEB, BRT, 1'b0, 1'b0);
    cyc(IDLE, ADV, 1'b0, 1'b0);

    // Load-use beats branch, then branch alone redirects.
    cyc(LU_BR, LUS, 1'b0, 1'b0);
    cyc(BR, BRT, 1'b0, 1'b0);
    cyc(IDLE, ADV, 1'b0, 1'b0);

    // Halt with three single steps, then release.
    do_reset();
    cyc(HALT, ADV, 1'b0, 1'b0);
    cyc(HALT, MST, 1'b1, 1'b0);
    repeat (3) begin
      cyc(HSTEP, MST, 1'b1, 1'b0);
      cyc(HALT, ADV, 1'b0, 1'b0);
      cyc(HALT, MST, 1'b1, 1'b0);
    end
    cyc(IDLE, MST, 1'b1, 1'b0);
    cyc(IDLE, ADV, 1'b0, 1'b0);

    // Halt requested during a memory wait is deferred until completion.
    cyc(MSTH, MST, 1'b0, 1'b0);
    cyc(MSTH, MST, 1'b0, 1'b0);
    cyc(MDONEH, ADV, 1'b0, 1'b0);
    cyc(IDLE, MST, 1'b1, 1'b0);
    cyc(IDLE, ADV, 1'b0, 1'b0);

    // Memory timeout after 4 wait cycles; wait holds even with mem_req dropped.
    do_reset();
    cyc(MSTALL, MST, 1'b0, 1'b0);
    cyc(MSTALL, MST, 1'b0, 1'b0);
    cyc(IDLE, MST, 1'b0, 1'b0);
    cyc(IDLE, MST, 1'b0, 1'b0);
    cyc(MSTALL, MST, 1'b0, 1'b0);
    cyc(IDLE, ADV, 1'b0, 1'b1);
    cyc(BR, BRT, 1'b0, 1'b1);
    cyc(IDLE, ADV, 1'b0, 1'b1);

    // Counter saturation, then asynchronous reset mid-run.
    do_reset();
    repeat (20) cyc(LU, LUS, 1'b0, 1'b0);
    do_reset();
    cyc(IDLE, ADV, 1'b0, 1'b0);
    cyc(IDLE, ADV, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
